// File: rtl/fu_arbiter_if.sv
// Handshake bundle between requesters, the shared functional unit and the response side
// of fu_arbiter. The arbiter connects through the slave modport.
interface fu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 4
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_1;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din_2;
  logic [NUM_REQ*4-1:0]          req_alu_sel;
  logic [NUM_REQ-1:0]            req_v;
  logic [NUM_REQ-1:0]            req_r;

  logic [DATA_WIDTH-1:0]         fu_din_1;
  logic [DATA_WIDTH-1:0]         fu_din_2;
  logic [3:0]                    fu_alu_sel;
  logic                          fu_din_v;
  logic                          fu_feedback;
  logic                          fu_din_r;

  logic [DATA_WIDTH-1:0]         fu_dout;
  logic                          fu_dout_v;
  logic                          fu_dout_r;

  logic [DATA_WIDTH-1:0]         rsp_dout;
  logic [NUM_REQ-1:0]            rsp_v;
  logic [NUM_REQ-1:0]            rsp_r;

  logic [CNT_W-1:0]              outstanding;
  logic                          err_orphan;

  modport slave (
    input  req_din_1, req_din_2, req_alu_sel, req_v, fu_din_r, fu_dout, fu_dout_v, rsp_r,
    output req_r, fu_din_1, fu_din_2, fu_alu_sel, fu_din_v, fu_feedback, fu_dout_r,
           rsp_dout, rsp_v, outstanding, err_orphan
  );

  modport master (
    output req_din_1, req_din_2, req_alu_sel, req_v, fu_din_r, fu_dout, fu_dout_v, rsp_r,
    input  req_r, fu_din_1, fu_din_2, fu_alu_sel, fu_din_v, fu_feedback, fu_dout_r,
           rsp_dout, rsp_v, outstanding, err_orphan
  );
endinterface

// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one functional unit between NUM_REQ requesters; a tag FIFO
// remembers who issued each operation so in-order results are routed back to the owner.
module fu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fu_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {ARB_FREE, ARB_LOCKED} arbState_e;

  arbState_e        state_q, state_d;
  idx_t             rrPtr_q, rrPtr_d;
  idx_t             lockIdx_q, lockIdx_d;
  idx_t             tagMem_q [TAG_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             errOrphan_q;

  idx_t             candIdx, grantIdx, headTag, probe;
  logic [31:0]      probeSum;
  logic             candFound, fifoFull, fifoEmpty, issueValid, push, pop;

  // Scan downward so the requester closest to rrPtr wins without needing a break.
  always_comb begin
    candFound = 1'b0;
    candIdx   = '0;
    probe     = '0;
    probeSum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      probeSum = (32'(rrPtr_q) + 32'(k)) % 32'(NUM_REQ);
      probe    = idx_t'(probeSum);
      if (bus.req_v[probe]) begin
        candFound = 1'b1;
        candIdx   = probe;
      end
    end
  end

  assign grantIdx   = (state_q == ARB_LOCKED) ? lockIdx_q : candIdx;
  assign fifoFull   = (count_q == CNT_W'(TAG_DEPTH));
  assign fifoEmpty  = (count_q == '0);
  assign issueValid = rst_n && ((state_q == ARB_LOCKED) || candFound) && !fifoFull;
  assign push       = issueValid && bus.fu_din_r;
  assign headTag    = tagMem_q[rdPtr_q];
  assign pop        = !fifoEmpty && bus.fu_dout_v && bus.rsp_r[headTag];

  // A stalled grant is held until the FU accepts it, so operands never switch mid-offer.
  always_comb begin
    state_d   = state_q;
    lockIdx_d = lockIdx_q;
    rrPtr_d   = rrPtr_q;
    case (state_q)
      ARB_FREE: begin
        if (issueValid && !bus.fu_din_r) begin
          state_d   = ARB_LOCKED;
          lockIdx_d = grantIdx;
        end
      end
      ARB_LOCKED: begin
        if (push) state_d = ARB_FREE;
      end
      default: state_d = ARB_FREE;
    endcase
    if (push) rrPtr_d = (grantIdx == idx_t'(NUM_REQ - 1)) ? '0 : grantIdx + idx_t'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    bus.fu_din_1   = '0;
    bus.fu_din_2   = '0;
    bus.fu_alu_sel = '0;
    bus.req_r      = '0;
    bus.rsp_v      = '0;
    bus.fu_dout_r  = 1'b1;
    if (issueValid) begin
      bus.fu_din_1        = bus.req_din_1[32'(grantIdx) * DATA_WIDTH +: DATA_WIDTH];
      bus.fu_din_2        = bus.req_din_2[32'(grantIdx) * DATA_WIDTH +: DATA_WIDTH];
      bus.fu_alu_sel      = bus.req_alu_sel[32'(grantIdx) * 4 +: 4];
      bus.req_r[grantIdx] = bus.fu_din_r;
    end
    // With no tag outstanding the result has no owner and is simply accepted and dropped.
    if (!fifoEmpty) begin
      bus.rsp_v[headTag] = bus.fu_dout_v;
      bus.fu_dout_r      = bus.rsp_r[headTag];
    end
  end

  assign bus.fu_din_v    = issueValid;
  assign bus.fu_feedback = 1'b0;
  assign bus.rsp_dout    = bus.fu_dout;
  assign bus.outstanding = count_q;
  assign bus.err_orphan  = errOrphan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_FREE;
      lockIdx_q   <= '0;
      rrPtr_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      errOrphan_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lockIdx_q <= lockIdx_d;
      rrPtr_q   <= rrPtr_d;
      count_q   <= count_d;
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (bus.fu_dout_v && fifoEmpty) errOrphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tagMem_q[wrPtr_q] <= grantIdx;
  end
endmodule

// File: doc/fu_arbiter.md
FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4, is the number of requesters, legal range 2..8.
REQ-003 Parameter TAG_DEPTH, default 4, is the depth of the outstanding-tag FIFO, a power of two of at least 2.
REQ-004 The clock and reset ports SHALL be clk, input, 1, clock; and rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 req_din_1 / req_din_2 SHALL be inputs of width NUM_REQ*DATA_WIDTH, the packed per-requester operands, with requester i in slice i.
REQ-006 req_alu_sel SHALL be an input of width NUM_REQ*4, the packed per-requester ALU opcodes.
REQ-007 req_v SHALL be a NUM_REQ-bit input and req_r a NUM_REQ-bit output, the per-requester issue handshake.
REQ-008 The FU issue outputs SHALL be fu_din_1 / fu_din_2 (DATA_WIDTH), fu_alu_sel (4) and fu_din_v (1), plus fu_feedback (1), tied to 0; the matching input SHALL be fu_din_r (1).
REQ-009 The FU result inputs SHALL be fu_dout (DATA_WIDTH) and fu_dout_v (1); the matching output SHALL be fu_dout_r (1).
REQ-010 The response outputs SHALL be rsp_dout (DATA_WIDTH, shared) and rsp_v (NUM_REQ); the matching input SHALL be rsp_r (NUM_REQ).
REQ-011 The status outputs SHALL be outstanding ($clog2(TAG_DEPTH)+1) and err_orphan (1).

Function
REQ-012 Arbitration SHALL be round-robin: search starts at index rr_ptr and wraps modulo NUM_REQ; the first requester with req_v=1 is the candidate.
REQ-013 fu_din_v SHALL be 1 iff a candidate or locked grant exists and the tag FIFO is not full.
REQ-014 fu_din_1, fu_din_2 and fu_alu_sel SHALL be driven combinationally from the granted requester's slices, and SHALL be 0 when fu_din_v=0.
REQ-015 req_r[g] SHALL equal fu_din_r AND fu_din_v for the granted index g; all other req_r bits SHALL be 0.
REQ-016 Grant lock: if fu_din_v=1 and fu_din_r=0, the grant index SHALL be registered, and the same index SHALL be granted every following cycle until the handshake completes, regardless of other req_v bits.
REQ-017 Issue handshake: fu_din_v=1 and fu_din_r=1 SHALL push g into the tag FIFO, clear the lock, and set rr_ptr to (g+1) mod NUM_REQ in the same edge.
REQ-018 FIFO full (outstanding==TAG_DEPTH) SHALL force fu_din_v=0 even if a pop occurs in the same cycle; issue resumes the cycle after the pop.
REQ-019 Response routing: with the FIFO non-empty and head tag t, rsp_v[t] SHALL equal fu_dout_v and fu_dout_r SHALL equal rsp_r[t]; all other rsp_v bits SHALL be 0.
REQ-020 rsp_dout SHALL equal fu_dout combinationally.
REQ-021 fu_dout_v=1 and fu_dout_r=1 SHALL pop the FIFO head.
REQ-022 A simultaneous push and pop SHALL leave outstanding unchanged, and FIFO order SHALL be preserved.
REQ-023 FIFO empty: rsp_v SHALL be all 0 and fu_dout_r SHALL be 1 (the result is dropped).
REQ-024 fu_dout_v=1 while the FIFO is empty SHALL set err_orphan, which stays set (sticky) until reset.
REQ-025 outstanding SHALL be the registered FIFO occupancy, 0..TAG_DEPTH.
REQ-026 Issue-to-result latency is determined by the FU (1 cycle nominal); the arbiter adds zero cycles on either path.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear rr_ptr, the lock, the FIFO pointers, outstanding and err_orphan.
REQ-028 During reset, fu_din_v, all req_r bits and all rsp_v bits SHALL be 0.
REQ-029 Reset mid-transaction SHALL discard all outstanding tags; results arriving after reset release SHALL set err_orphan.

Verification
REQ-030 Round-robin: req_v=4'b1111, fu_din_r=1 constant -> grants issue in the order 0,1,2,3,0,…, one per cycle.
REQ-031 Lock: req 2 granted, fu_din_r=0 for 3 cycles while req_v[0] rises -> grant stays 2 with stable operands, then req 2 issues, then req 0.
REQ-032 Routing: req 1 issues 5+7 (alu_sel=0), then req 3 issues 6*3 (alu_sel=1) -> rsp_v[1] with rsp_dout=12, then rsp_v[3] with 18.
REQ-033 Full/backpressure: TAG_DEPTH=4, rsp_r=0, req 0 issues 4 times -> outstanding=4 and fu_din_v=0; rsp_r[0]=1 for one pop -> issue resumes the next cycle.
REQ-034 Orphan: fu_dout_v=1 with outstanding=0 -> err_orphan=1 until rst_n=0.
REQ-035 Reset: assert rst_n=0 with outstanding=3 -> outstanding=0 and rr_ptr=0 immediately; after release the first grant goes to the lowest-index active requester.
